fp16_sub_seq: RTL and testbench
===============================

Name: fp16_sub_seq

Overview:
- Multi-cycle IEEE-754 binary16 subtractor, Q = A - B.
- Registers operands on a start/done handshake.
- Drives the combinational special-case stage magnitude16_sub with B's sign inverted. When that stage asserts exc, its Q is the result; otherwise the block runs align / subtract / normalize / round over several cycles.
- Sits between the operand issue logic and the result writeback of the half-precision unit.

Parameters:
NORM_MAX, 11, maximum 1-bit normalization shift cycles (one per cycle); must cover a full 11-bit significand.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
start  in  1  request; sampled only in IDLE.
a  in  16  operand A (binary16).
b  in  16  operand B (binary16).
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse; q/flags are valid from this cycle onward.
q  out  16  result; held until the next accepted start completes.
flags  out  5  [4]=NV invalid, [3]=0 reserved, [2]=UF, [1]=OF, [0]=NX; held with q.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, q=16'h0000, flags=5'b0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE -> CHECK -> (exc ? IDLE : ALIGN) -> SUB -> NORM -> ROUND -> IDLE.
- IDLE: start=1 latches a and b, then goes to CHECK. start while busy is ignored, with no effect on the operation in flight.
- CHECK: feeds SIGN_A=a[15], SIGN_B=~b[15] plus the exponent and mantissa fields to magnitude16_sub.
  - If exc=1: q <= stage Q, done pulses, return to IDLE.
  - Both-zero override: q={a[15]&~b[15],15'b0}.
  - NV=1 if Inf-Inf of like sign, or if any input is an sNaN (exp=31, mant!=0, mant[9]=0).
  - All other flags are 0 on this path.
- ALIGN: significands take the hidden bit (0 for exp=0; subnormal effective exp=1).
  - Extend to 14 bits with guard/round/sticky.
  - Right-shift the smaller-magnitude operand by the exponent difference in one cycle; shifted-out bits OR into sticky.
  - Shift >= 14 leaves sticky only.
- SUB: effective operation = add if a[15]!=b[15], else subtract larger minus smaller magnitude.
  - Result sign = sign of the larger magnitude (A's sign if A is larger, ~b[15] if B is larger).
  - Exact zero result -> +0 (RNE mode); q=0, go straight to ROUND with no flags.
  - Carry-out -> shift right 1, exp+1, LSB into sticky.
- NORM: while hidden bit is 0 and exp > 1, left-shift 1 bit and decrement exp; one bit per cycle, at most NORM_MAX cycles.
  - Stopping at exp=1 with hidden bit 0 gives a subnormal, encoded with exp=0.
- ROUND: round-to-nearest, ties-to-even, on guard/round/sticky.
  - Mantissa overflow increments exp.
  - exp >= 31 after rounding -> q=±Inf, OF=1, NX=1.
  - NX = any of guard/round/sticky set.
  - UF = tiny (result subnormal before rounding) AND NX.
  - Then done pulses and the FSM returns to IDLE.
- done is high in the same cycle state returns to IDLE; a start in that cycle is accepted.
- Latency (start-sampled edge to done-high cycle):
  - exception path: 2 cycles;
  - normal path: 5 + n cycles, n = NORM iterations (0..11); max 16.
- q and flags update only at completion; they are stable while busy.

Test Plan:
- a=16'h4200 (3.0), b=16'h3C00 (1.0) -> q=16'h4000, flags=5'b00000, done after 5 cycles (n=0), busy high throughout.
- a=16'h3C00, b=16'h3C00 -> q=16'h0000 (+0), flags=0. Also a=16'h8000, b=16'h0000 -> q=16'h8000, exception path, done after 2 cycles.
- a=16'h7C00, b=16'h7C00 (Inf-Inf) -> q=16'h7E00, flags=5'b10000, done at 2 cycles. Also a=16'h7C00, b=16'hFC00 -> q=16'h7C00, flags=0.
- a=16'h7BFF, b=16'hFBFF -> q=16'h7C00, flags=5'b00011. Also a=16'h3C00, b=16'h0001 -> q=16'h3C00, flags=5'b00001.
- a=16'h0400, b=16'h0001 -> q=16'h03FF, flags=0 (exact subnormal, UF=0). Also a=16'h3C01, b=16'h3C00 -> q=16'h1400, n=10, done at 15 cycles.
- Assert rst during NORM of the 3C01-3C00 case -> busy=0, q=0, flags=0, no done. Then start a=16'h4200, b=16'h3C00 -> correct 16'h4000. Also hold start high while busy: the second request is ignored until done.

Source files
------------

// File: rtl/fp16_sub_seq.sv
// Multi-cycle binary16 subtractor (Q = A - B) with a start/done handshake.
// Special operands resolve in one check cycle; finite operands go through align/sub/norm/round.

module magnitude16_sub (
   input  logic        sign_a_i,
   input  logic        sign_b_i,
   input  logic [4:0]  exp_a_i,
   input  logic [9:0]  man_a_i,
   input  logic [4:0]  exp_b_i,
   input  logic [9:0]  man_b_i,
   output logic        exc_o,
   output logic [15:0] q_o,
   output logic        nv_o
);
   logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

   assign nan_a  = (exp_a_i == 5'h1F) && (man_a_i != 10'h0);
   assign nan_b  = (exp_b_i == 5'h1F) && (man_b_i != 10'h0);
   assign snan_a = nan_a && !man_a_i[9];
   assign snan_b = nan_b && !man_b_i[9];
   assign inf_a  = (exp_a_i == 5'h1F) && (man_a_i == 10'h0);
   assign inf_b  = (exp_b_i == 5'h1F) && (man_b_i == 10'h0);
   assign zero_a = (exp_a_i == 5'h00) && (man_a_i == 10'h0);
   assign zero_b = (exp_b_i == 5'h00) && (man_b_i == 10'h0);

   // sign_b_i is already the effective (inverted) sign, so this is an addition
   always_comb begin
      exc_o = 1'b0;
      q_o   = 16'h0000;
      nv_o  = 1'b0;
      if (nan_a || nan_b) begin
         exc_o = 1'b1;
         q_o   = 16'h7E00;
         nv_o  = snan_a || snan_b;
      end else if (inf_a && inf_b) begin
         exc_o = 1'b1;
         if (sign_a_i != sign_b_i) begin
            q_o  = 16'h7E00;
            nv_o = 1'b1;
         end else begin
            q_o = {sign_a_i, 5'h1F, 10'h000};
         end
      end else if (inf_a) begin
         exc_o = 1'b1;
         q_o   = {sign_a_i, 5'h1F, 10'h000};
      end else if (inf_b) begin
         exc_o = 1'b1;
         q_o   = {sign_b_i, 5'h1F, 10'h000};
      end else if (zero_a && zero_b) begin
         exc_o = 1'b1;
         q_o   = {sign_a_i & sign_b_i, 15'h0000};
      end
   end
endmodule

module fp16_sub_seq #(
   parameter int NORM_MAX = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] q,
   output logic [4:0]  flags
);
   localparam int CW = $clog2(NORM_MAX + 1);

   typedef enum logic [2:0] {IDLE, CHECK, ALIGN, SUB, NORM, ROUND} state_t;

   state_t         state_q, state_d;
   logic [15:0]    a_q, a_d, b_q, b_d;
   logic [13:0]    sig_l_q, sig_l_d, sig_s_q, sig_s_d;
   logic [5:0]     exp_q, exp_d;
   logic [4:0]     diff_q, diff_d;
   logic           sign_q, sign_d, zero_q, zero_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    q_q, q_d;
   logic [4:0]     flags_q, flags_d;
   logic           done_q, done_d;

   logic        exc, nv;
   logic [15:0] exc_q;
   logic [4:0]  ea_eff, eb_eff;
   logic        a_big, eff_sub;
   logic [13:0] sig_a, sig_b;

   magnitude16_sub u_special (
      .sign_a_i (a_q[15]),
      .sign_b_i (~b_q[15]),
      .exp_a_i  (a_q[14:10]),
      .man_a_i  (a_q[9:0]),
      .exp_b_i  (b_q[14:10]),
      .man_b_i  (b_q[9:0]),
      .exc_o    (exc),
      .q_o      (exc_q),
      .nv_o     (nv)
   );

   // Subnormals carry a zero hidden bit and an effective exponent of 1
   assign ea_eff  = (a_q[14:10] == 5'h00) ? 5'd1 : a_q[14:10];
   assign eb_eff  = (b_q[14:10] == 5'h00) ? 5'd1 : b_q[14:10];
   assign sig_a   = {a_q[14:10] != 5'h00, a_q[9:0], 3'b000};
   assign sig_b   = {b_q[14:10] != 5'h00, b_q[9:0], 3'b000};
   assign a_big   = a_q[14:0] >= b_q[14:0];
   assign eff_sub = (a_q[15] == b_q[15]);

   logic [13:0] sh_val, sh_mask;
   logic        sh_sticky;

   always_comb begin
      sh_val    = 14'h0;
      sh_mask   = 14'h0;
      sh_sticky = 1'b0;
      if (diff_q >= 5'd14) begin
         sh_sticky = |sig_s_q;
      end else begin
         sh_val    = sig_s_q >> diff_q[3:0];
         sh_mask   = (14'd1 << diff_q[3:0]) - 14'd1;
         sh_sticky = |(sig_s_q & sh_mask);
      end
   end

   logic [14:0] sum;
   assign sum = eff_sub ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});

   logic        rnd_up, hid, tiny, nx, of, uf;
   logic [11:0] m12;
   logic [5:0]  exp_r;
   logic [9:0]  frac;
   logic [15:0] rnd_q;
   logic [4:0]  rnd_flags;

   // Round to nearest even on the G/R/S bits held in sig_l_q[2:0]
   always_comb begin
      rnd_up    = sig_l_q[2] & (sig_l_q[1] | sig_l_q[0] | sig_l_q[3]);
      m12       = {1'b0, sig_l_q[13:3]} + {11'b0, rnd_up};
      exp_r     = exp_q + {5'b0, m12[11]};
      frac      = m12[11] ? m12[10:1] : m12[9:0];
      hid       = m12[11] | m12[10];
      tiny      = ~sig_l_q[13];
      of        = exp_r >= 6'd31;
      nx        = (|sig_l_q[2:0]) | of;
      uf        = tiny & nx;
      rnd_q     = {sign_q, hid ? exp_r[4:0] : 5'd0, frac};
      rnd_flags = {1'b0, 1'b0, uf, of, nx};
      if (zero_q) begin
         rnd_q     = 16'h0000;
         rnd_flags = 5'b00000;
      end else if (of) begin
         rnd_q = {sign_q, 5'h1F, 10'h000};
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sig_l_d = sig_l_q;
      sig_s_d = sig_s_q;
      exp_d   = exp_q;
      diff_d  = diff_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (exc) begin
               q_d     = exc_q;
               flags_d = {nv, 4'b0000};
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               zero_d  = 1'b0;
               cnt_d   = '0;
               if (a_big) begin
                  sig_l_d = sig_a;
                  sig_s_d = sig_b;
                  exp_d   = {1'b0, ea_eff};
                  diff_d  = ea_eff - eb_eff;
                  sign_d  = a_q[15];
               end else begin
                  sig_l_d = sig_b;
                  sig_s_d = sig_a;
                  exp_d   = {1'b0, eb_eff};
                  diff_d  = eb_eff - ea_eff;
                  sign_d  = ~b_q[15];
               end
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            sig_s_d = {sh_val[13:1], sh_val[0] | sh_sticky};
            state_d = SUB;
         end
         SUB: begin
            if (sum == 15'h0) begin
               zero_d  = 1'b1;
               sig_l_d = 14'h0;
               state_d = ROUND;
            end else if (sum[14]) begin
               sig_l_d = {sum[14:2], sum[1] | sum[0]};
               exp_d   = exp_q + 6'd1;
               state_d = ROUND;
            end else begin
               sig_l_d = sum[13:0];
               state_d = (!sum[13] && exp_q > 6'd1) ? NORM : ROUND;
            end
         end
         NORM: begin
            sig_l_d = {sig_l_q[12:0], 1'b0};
            exp_d   = exp_q - 6'd1;
            cnt_d   = cnt_q + 1'b1;
            if (sig_l_d[13] || exp_d == 6'd1 || cnt_d == CW'(NORM_MAX))
               state_d = ROUND;
         end
         ROUND: begin
            q_d     = rnd_q;
            flags_d = rnd_flags;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 16'h0;
         b_q     <= 16'h0;
         sig_l_q <= 14'h0;
         sig_s_q <= 14'h0;
         exp_q   <= 6'h0;
         diff_q  <= 5'h0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
         q_q     <= 16'h0;
         flags_q <= 5'h0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sig_l_q <= sig_l_d;
         sig_s_q <= sig_s_d;
         exp_q   <= exp_d;
         diff_q  <= diff_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign q     = q_q;
   assign flags = flags_q;
endmodule

// File: tb/tb_fp16_sub_seq.sv
// Directed-vector bench for fp16_sub_seq: result, flags, latency, busy/done handshake, reset abort.

module tb_fp16_sub_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = 16'h0, b = 16'h0;
   logic        busy, done;
   logic [15:0] q;
   logic [4:0]  flags;

   int n_cmp = 0;
   int n_bad = 0;

   fp16_sub_seq #(.NORM_MAX(11)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .flags (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [4:0]  fl;
      int          lat;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one operation; start sampled at the next edge, latency counted from that edge as 1
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit hold,
                         input logic [15:0] ha, input logic [15:0] hb,
                         output int lat, output bit busy_ok);
      @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      if (hold) begin
         a = ha; b = hb;
      end else begin
         start = 1'b0;
      end
      lat = 1;
      busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
   endtask

   int lat;
   bit bok;
   int seen;

   initial begin
      tbl[0]  = '{16'h4200, 16'h3C00, 16'h4000, 5'b00000, 5};
      tbl[1]  = '{16'h3C00, 16'h3C00, 16'h0000, 5'b00000, 5};
      tbl[2]  = '{16'h8000, 16'h0000, 16'h8000, 5'b00000, 2};
      tbl[3]  = '{16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 2};
      tbl[4]  = '{16'h7C00, 16'hFC00, 16'h7C00, 5'b00000, 2};
      tbl[5]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 5'b00011, 5};
      tbl[6]  = '{16'h3C00, 16'h0001, 16'h3C00, 5'b00001, 6};
      tbl[7]  = '{16'h0400, 16'h0001, 16'h03FF, 5'b00000, 5};
      tbl[8]  = '{16'h3C01, 16'h3C00, 16'h1400, 5'b00000, 15};
      tbl[9]  = '{16'h3C00, 16'hBC00, 16'h4000, 5'b00000, 5};
      tbl[10] = '{16'h0000, 16'h3C00, 16'hBC00, 5'b00000, 5};
      tbl[11] = '{16'h3C00, 16'h7C00, 16'hFC00, 5'b00000, 2};
      tbl[12] = '{16'h7D00, 16'h3C00, 16'h7E00, 5'b10000, 2};
      tbl[13] = '{16'h0001, 16'h8001, 16'h0002, 5'b00000, 5};
      tbl[14] = '{16'h7E00, 16'h3C00, 16'h7E00, 5'b00000, 2};

      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_q", {16'b0, q}, 32'h0);
      chk("rst_flags", {27'b0, flags}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op(tbl[i].a, tbl[i].b, 1'b0, 16'h0, 16'h0, lat, bok);
         chk($sformatf("v%0d_q", i), {16'b0, q}, {16'b0, tbl[i].q});
         chk($sformatf("v%0d_flags", i), {27'b0, flags}, {27'b0, tbl[i].fl});
         chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("v%0d_busy", i), {31'b0, bok}, 32'd1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse", i), {31'b0, done}, 32'd0);
         chk($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
         chk($sformatf("v%0d_hold_q", i), {16'b0, q}, {16'b0, tbl[i].q});
      end

      // Reset while normalizing 3C01-3C00 (NORM spans latency 4..13)
      @(negedge clk);
      a = 16'h3C01; b = 16'h3C00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("mid_busy_pre", {31'b0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_q", {16'b0, q}, 32'h0);
      chk("abort_flags", {27'b0, flags}, 32'h0);
      chk("abort_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);
      run_op(16'h4200, 16'h3C00, 1'b0, 16'h0, 16'h0, lat, bok);
      chk("post_rst_q", {16'b0, q}, 32'h4000);
      chk("post_rst_lat", lat, 5);

      // start held high with different operands while busy must not disturb the operation
      run_op(16'h4200, 16'h3C00, 1'b1, 16'h3C00, 16'h3C00, lat, bok);
      chk("hold_q", {16'b0, q}, 32'h4000);
      chk("hold_lat", lat, 5);
      chk("hold_busy", {31'b0, bok}, 32'd1);
      @(posedge clk); #1;
      chk("hold_idle", {31'b0, busy}, 32'd0);

      // start in the done cycle is accepted
      @(negedge clk);
      a = 16'h3C00; b = 16'h3C00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_first_q", {16'b0, q}, 32'h0000);
      a = 16'h4200; b = 16'h3C00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_accept", {31'b0, busy}, 32'd1);
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_second_q", {16'b0, q}, 32'h4000);
      chk("b2b_second_lat", lat, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
